// File: rtl/ikaz_pkg.sv
// Shared types and default timing for the buzzer warning controller.
// The MUTED state exists only when IKAZ_SUSTURMA_EN is defined.
package ikaz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEB     = 3'd1,
    ST_SLOW    = 3'd2,
    ST_FAST    = 3'd3,
    ST_TIMEOUT = 3'd4
`ifdef IKAZ_SUSTURMA_EN
    ,
    ST_MUTED   = 3'd5
`endif
  } durum_e;

  localparam int unsigned DEF_TICK_DIV    = 100000;
  localparam int unsigned DEF_DEB_MS      = 20;
  localparam int unsigned DEF_SLOW_ON_MS  = 250;
  localparam int unsigned DEF_SLOW_OFF_MS = 750;
  localparam int unsigned DEF_FAST_ON_MS  = 125;
  localparam int unsigned DEF_FAST_OFF_MS = 125;
  localparam int unsigned DEF_SLOW_CYC    = 8;
  localparam int unsigned DEF_FAST_CYC    = 40;

  // Used for sizing counters from the parameter set.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ikaz_tick_gen.sv
// Free-running 1 ms tick generator: one-clk tick every TICK_DIV clks.
module ikaz_tick_gen
  import ikaz_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Divider wraps at TICK_DIV-1 and emits a registered tick on the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/ikaz_zil_kontrol.sv
// Seatbelt/door buzzer controller: debounce, slow then fast beep pattern,
// timeout. Optional mute button/state enabled by macro IKAZ_SUSTURMA_EN.
module ikaz_zil_kontrol
  import ikaz_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned DEB_MS      = DEF_DEB_MS,
  parameter int unsigned SLOW_ON_MS  = DEF_SLOW_ON_MS,
  parameter int unsigned SLOW_OFF_MS = DEF_SLOW_OFF_MS,
  parameter int unsigned FAST_ON_MS  = DEF_FAST_ON_MS,
  parameter int unsigned FAST_OFF_MS = DEF_FAST_OFF_MS,
  parameter int unsigned SLOW_CYC    = DEF_SLOW_CYC,
  parameter int unsigned FAST_CYC    = DEF_FAST_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       motor_durumu,
  input  logic       emniyet_kemeri_ikaz,
  input  logic       kapi_ikaz,
`ifdef IKAZ_SUSTURMA_EN
  input  logic       susturma_btn,
`endif
  output logic       zil,
  output logic       ikaz_aktif,
  output logic [2:0] durum
);

  localparam int unsigned MS_MAX = max2(max2(DEB_MS, max2(SLOW_ON_MS, SLOW_OFF_MS)),
                                        max2(FAST_ON_MS, FAST_OFF_MS));
  localparam int unsigned MS_W   = (MS_MAX > 0) ? $clog2(MS_MAX + 1) : 1;
  localparam int unsigned PER_W  = $clog2(max2(SLOW_CYC, FAST_CYC) + 1);

  localparam logic [MS_W-1:0]  DEB_LIM      = MS_W'(DEB_MS - 1);
  localparam logic [MS_W-1:0]  SLOW_ON_LIM  = MS_W'(SLOW_ON_MS - 1);
  localparam logic [MS_W-1:0]  SLOW_OFF_LIM = MS_W'(SLOW_OFF_MS - 1);
  localparam logic [MS_W-1:0]  FAST_ON_LIM  = MS_W'(FAST_ON_MS - 1);
  localparam logic [MS_W-1:0]  FAST_OFF_LIM = MS_W'(FAST_OFF_MS - 1);
  localparam logic [PER_W-1:0] SLOW_CYC_LIM = PER_W'(SLOW_CYC - 1);
  localparam logic [PER_W-1:0] FAST_CYC_LIM = PER_W'(FAST_CYC - 1);

  durum_e           r_state;
  logic [MS_W-1:0]  r_ms;
  logic [PER_W-1:0] r_per;
  logic             r_on;
  logic             r_zil;
  logic             r_aktif;
  logic             r_kapi_d;

  logic             w_tick;
  logic             w_istek;
  logic             w_kapi_rise;
  logic [MS_W-1:0]  w_phase_lim;
  logic [PER_W-1:0] w_cyc_lim;

  ikaz_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_istek     = motor_durumu & (emniyet_kemeri_ikaz | kapi_ikaz);
  assign w_kapi_rise = kapi_ikaz & ~r_kapi_d;

  // Select the tick limit of the current phase and the period limit of the current pattern.
  always_comb begin
    w_phase_lim = FAST_OFF_LIM;
    w_cyc_lim   = FAST_CYC_LIM;
    if (r_state == ST_SLOW) begin
      w_phase_lim = r_on ? SLOW_ON_LIM : SLOW_OFF_LIM;
      w_cyc_lim   = SLOW_CYC_LIM;
    end else begin
      w_phase_lim = r_on ? FAST_ON_LIM : FAST_OFF_LIM;
    end
  end

  // Main FSM; zil follows r_on one clk late, so every state change forces it to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ms     <= '0;
      r_per    <= '0;
      r_on     <= 1'b0;
      r_zil    <= 1'b0;
      r_aktif  <= 1'b0;
      r_kapi_d <= 1'b0;
    end else begin
      r_kapi_d <= kapi_ikaz;
      r_zil    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_istek) begin
            r_state <= ST_DEB;
            r_ms    <= '0;
          end
        end
        ST_DEB: begin
          if (!w_istek) begin
            r_state <= ST_IDLE;
            r_ms    <= '0;
          end else if (w_tick) begin
            if (r_ms == DEB_LIM) begin
              r_state <= kapi_ikaz ? ST_FAST : ST_SLOW;
              r_aktif <= 1'b1;
              r_ms    <= '0;
              r_per   <= '0;
              r_on    <= 1'b1;
            end else begin
              r_ms <= r_ms + 1'b1;
            end
          end
        end
        ST_SLOW, ST_FAST: begin
          if (!w_istek) begin
            r_state <= ST_IDLE;
            r_aktif <= 1'b0;
            r_ms    <= '0;
            r_per   <= '0;
            r_on    <= 1'b0;
          end else if ((r_state == ST_SLOW) && w_kapi_rise) begin
            r_state <= ST_FAST;
            r_ms    <= '0;
            r_per   <= '0;
            r_on    <= 1'b1;
`ifdef IKAZ_SUSTURMA_EN
          end else if (susturma_btn) begin
            r_state <= ST_MUTED;
            r_ms    <= '0;
            r_per   <= '0;
            r_on    <= 1'b0;
`endif
          end else begin
            r_zil <= r_on;
            if (w_tick) begin
              if (r_ms == w_phase_lim) begin
                r_ms <= '0;
                r_on <= ~r_on;
                if (!r_on) begin
                  if (r_per == w_cyc_lim) begin
                    r_state <= (r_state == ST_SLOW) ? ST_FAST : ST_TIMEOUT;
                    r_per   <= '0;
                    r_on    <= (r_state == ST_SLOW);
                  end else if (r_per != '1) begin
                    r_per <= r_per + 1'b1;
                  end
                end
              end else if (r_ms != '1) begin
                r_ms <= r_ms + 1'b1;
              end
            end
          end
        end
        ST_TIMEOUT: begin
          if (!w_istek) begin
            r_state <= ST_IDLE;
            r_aktif <= 1'b0;
          end
        end
`ifdef IKAZ_SUSTURMA_EN
        ST_MUTED: begin
          if (!w_istek) begin
            r_state <= ST_IDLE;
            r_aktif <= 1'b0;
          end else if (w_kapi_rise) begin
            r_state <= ST_FAST;
            r_ms    <= '0;
            r_per   <= '0;
            r_on    <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_aktif <= 1'b0;
          r_ms    <= '0;
          r_per   <= '0;
          r_on    <= 1'b0;
        end
      endcase
    end
  end

  assign zil        = r_zil;
  assign ikaz_aktif = r_aktif;
  assign durum      = r_state;

endmodule

// File: tb/tb_ikaz_zil_kontrol.sv
// Directed scoreboard bench for ikaz_zil_kontrol (small timing parameters).
module tb_ikaz_zil_kontrol;

  localparam int unsigned TD    = 4;
  localparam int unsigned DEB   = 3;
  localparam int unsigned SON   = 2;
  localparam int unsigned SOFF  = 2;
  localparam int unsigned FON   = 1;
  localparam int unsigned FOFF  = 1;
  localparam int unsigned SCYC  = 2;
  localparam int unsigned FCYC  = 3;

  localparam int unsigned DEB_CLK   = DEB * TD;
  localparam int unsigned S_PER     = (SON + SOFF) * TD;
  localparam int unsigned F_PER     = (FON + FOFF) * TD;
  localparam int unsigned S_LEN     = S_PER * SCYC;
  localparam int unsigned F_LEN     = F_PER * FCYC;

  logic       clk;
  logic       rst_n;
  logic       motor_durumu;
  logic       emniyet_kemeri_ikaz;
  logic       kapi_ikaz;
`ifdef IKAZ_SUSTURMA_EN
  logic       susturma_btn;
`endif
  logic       zil;
  logic       ikaz_aktif;
  logic [2:0] durum;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;

  exp_t sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ikaz_zil_kontrol #(
    .TICK_DIV    (TD),
    .DEB_MS      (DEB),
    .SLOW_ON_MS  (SON),
    .SLOW_OFF_MS (SOFF),
    .FAST_ON_MS  (FON),
    .FAST_OFF_MS (FOFF),
    .SLOW_CYC    (SCYC),
    .FAST_CYC    (FCYC)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .motor_durumu        (motor_durumu),
    .emniyet_kemeri_ikaz (emniyet_kemeri_ikaz),
    .kapi_ikaz           (kapi_ikaz),
`ifdef IKAZ_SUSTURMA_EN
    .susturma_btn        (susturma_btn),
`endif
    .zil                 (zil),
    .ikaz_aktif          (ikaz_aktif),
    .durum               (durum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic z, input logic a, input logic [2:0] d);
    exp_t e;
    e.tag = tag;
    e.exp = {z, a, d};
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t       e;
    logic [4:0] obs;
    obs = {zil, ikaz_aktif, durum};
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: got %b, want an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: got zil=%b aktif=%b durum=%0d, want zil=%b aktif=%b durum=%0d",
               e.tag, obs[4], obs[3], obs[2:0], e.exp[4], e.exp[3], e.exp[2:0]);
      end
    end
  endtask

  task automatic run_checks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      check_pop();
    end
  endtask

  task automatic wait_durum(input string tag, input logic [2:0] d, input int unsigned budget);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (durum === d) ok = 1'b1;
    end
    n_tests++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: durum=%0d, want %0d within %0d clk", tag, durum, d, budget);
    end
  endtask

  task automatic wait_zil(input string tag, input int unsigned budget);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (zil === 1'b1) ok = 1'b1;
    end
    n_tests++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: zil=%b, want 1 within %0d clk", tag, zil, budget);
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    motor_durumu        = 1'b0;
    emniyet_kemeri_ikaz = 1'b0;
    kapi_ikaz           = 1'b0;
`ifdef IKAZ_SUSTURMA_EN
    susturma_btn        = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    push("reset", 1'b0, 1'b0, 3'd0);
    check_pop();

    // Full sequence from reset release: DEB, SLOW, FAST, TIMEOUT
    motor_durumu        = 1'b1;
    emniyet_kemeri_ikaz = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned j = 0; j < DEB_CLK; j++) push("s1_deb", 1'b0, 1'b0, 3'd1);
    for (int unsigned j = 0; j < S_LEN; j++)
      push("s1_slow", (j >= 1) && (((j - 1) % S_PER) < SON * TD), 1'b1, 3'd2);
    for (int unsigned j = 0; j < F_LEN; j++)
      push("s1_fast", (j >= 1) && (((j - 1) % F_PER) < FON * TD), 1'b1, 3'd3);
    for (int unsigned j = 0; j < 6; j++) push("s1_timeout", 1'b0, 1'b1, 3'd4);
    run_checks(DEB_CLK + S_LEN + F_LEN + 6);
    emniyet_kemeri_ikaz = 1'b0;
    push("s1_timeout_exit", 1'b0, 1'b0, 3'd0);
    run_checks(1);

    // Short request aborts the debounce
    emniyet_kemeri_ikaz = 1'b1;
    for (int unsigned j = 0; j < 8; j++) push("s2_deb", 1'b0, 1'b0, 3'd1);
    run_checks(8);
    emniyet_kemeri_ikaz = 1'b0;
    push("s2_abort", 1'b0, 1'b0, 3'd0);
    push("s2_idle",  1'b0, 1'b0, 3'd0);
    run_checks(2);

    // Door rising during the slow on-phase switches to FAST
    emniyet_kemeri_ikaz = 1'b1;
    wait_durum("s3_reach_slow", 3'd2, DEB_CLK + 4);
    wait_zil("s3_slow_on", 4);
    kapi_ikaz = 1'b1;
    push("s3_door_fast", 1'b0, 1'b1, 3'd3);
    push("s3_fast_on",   1'b1, 1'b1, 3'd3);
    run_checks(2);

    // Motor drop in FAST while sounding
    motor_durumu = 1'b0;
    push("s4_motor_off", 1'b0, 1'b0, 3'd0);
    run_checks(1);

    // Door held through debounce goes to FAST; reset mid-FAST restarts debounce
    motor_durumu = 1'b1;
    wait_durum("s5_reach_fast", 3'd3, DEB_CLK + 6);
    wait_zil("s5_fast_on", 4);
    rst_n = 1'b0;
    #1;
    push("s5_async_reset", 1'b0, 1'b0, 3'd0);
    check_pop();
    push("s5_in_reset", 1'b0, 1'b0, 3'd0);
    run_checks(1);
    rst_n = 1'b1;
    for (int unsigned j = 0; j < DEB_CLK; j++) push("s5_redeb", 1'b0, 1'b0, 3'd1);
    push("s5_fast_entry", 1'b0, 1'b1, 3'd3);
    push("s5_fast_on",    1'b1, 1'b1, 3'd3);
    run_checks(DEB_CLK + 2);

`ifdef IKAZ_SUSTURMA_EN
    // Mute in SLOW, then door overrides mute
    kapi_ikaz           = 1'b0;
    emniyet_kemeri_ikaz = 1'b0;
    push("s6_idle", 1'b0, 1'b0, 3'd0);
    run_checks(1);
    emniyet_kemeri_ikaz = 1'b1;
    wait_durum("s6_reach_slow", 3'd2, DEB_CLK + 4);
    wait_zil("s6_slow_on", 4);
    susturma_btn = 1'b1;
    @(negedge clk);
    susturma_btn = 1'b0;
    push("s6_muted", 1'b0, 1'b1, 3'd5);
    check_pop();
    for (int unsigned j = 0; j < 5; j++) push("s6_muted_hold", 1'b0, 1'b1, 3'd5);
    run_checks(5);
    kapi_ikaz = 1'b1;
    push("s6_door_fast", 1'b0, 1'b1, 3'd3);
    push("s6_fast_on",   1'b1, 1'b1, 3'd3);
    run_checks(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ikaz_zil_kontrol.md
IKAZ_ZIL_KONTROL -- requirements
Module: ikaz_zil_kontrol

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk cycles per 1 ms time tick.
REQ-002 Parameter DEB_MS, default 20, ms a warning input must hold before it is accepted.
REQ-003 Parameter SLOW_ON_MS / SLOW_OFF_MS, defaults 250 / 750, slow beep on/off times in ms.
REQ-004 Parameter FAST_ON_MS / FAST_OFF_MS, defaults 125 / 125, fast beep on/off times in ms.
REQ-005 Parameter SLOW_CYC / FAST_CYC, defaults 8 / 40, beep periods spent in the slow / fast phase.
REQ-006 clk  in  1  single system clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 motor_durumu  in  1  1 = engine running.
REQ-009 emniyet_kemeri_ikaz  in  1  seatbelt warning request from the upstream warning logic.
REQ-010 kapi_ikaz  in  1  door warning request from the upstream warning logic.
REQ-011 susturma_btn  in  1  mute request, one-clk pulse (present only with IKAZ_SUSTURMA_EN).
REQ-012 zil  out  1  buzzer drive, 1 = sounding.
REQ-013 ikaz_aktif  out  1  1 while an accepted warning is being handled (all states except IDLE/DEB).
REQ-014 durum  out  3  current FSM state encoding, for the dashboard and debug.

Function
REQ-015 Internal request istek = motor_durumu & (emniyet_kemeri_ikaz | kapi_ikaz); kapi_ikaz has priority for pattern selection.
REQ-016 Time base: a 1 ms tick pulse, one clk wide, every TICK_DIV clks; the free-running divider never stops.
REQ-017 FSM states: IDLE=0, DEB=1, SLOW=2, FAST=3, TIMEOUT=4, MUTED=5.
REQ-018 IDLE -> DEB when istek=1; the ms counter clears on entry.
REQ-019 DEB -> IDLE when istek=0 at any clk; DEB -> SLOW after DEB_MS ticks with istek continuously 1; DEB -> FAST instead if kapi_ikaz=1 at that moment.
REQ-020 SLOW: zil=1 for SLOW_ON_MS ticks, then 0 for SLOW_OFF_MS ticks, per period; after SLOW_CYC periods -> FAST.
REQ-021 FAST: zil=1 for FAST_ON_MS ticks, then 0 for FAST_OFF_MS ticks; after FAST_CYC periods -> TIMEOUT.
REQ-022 kapi_ikaz rising while in SLOW -> FAST on the next clk; the period counter clears and the pattern starts in its on-phase.
REQ-023 TIMEOUT: zil=0; exit to IDLE only when istek=0.
REQ-024 From SLOW, FAST, TIMEOUT or MUTED: istek=0 -> IDLE on the next clk, and zil=0 on that same next clk.
REQ-025 zil is registered and is 1 only in the on-phase of SLOW/FAST; it is 0 in every other state.
REQ-026 Each beep period starts with its on-phase; the first zil=1 occurs one clk after the state entry.
REQ-027 Phase and period counters clear on every state change and saturate; they never wrap.
REQ-028 motor_durumu falling forces istek=0 and so exits per REQ-024.

Reset
REQ-029 rst_n=0 asynchronously sets FSM=IDLE, clears all counters and the tick divider, and drives zil=0, ikaz_aktif=0, durum=0.
REQ-030 Reset asserted mid-pattern stops the buzzer immediately with no trailing pulse.
REQ-031 After release, the FSM restarts from IDLE; istek still high re-enters DEB with the full debounce time.

Configuration
REQ-032 Macro IKAZ_SUSTURMA_EN defined: susturma_btn=1 in SLOW or FAST -> MUTED on the next clk, with zil=0.
REQ-033 MUTED is left only via istek=0 -> IDLE; kapi_ikaz rising while MUTED -> FAST (door overrides mute).
REQ-034 Macro undefined: the susturma_btn port and the MUTED state are absent, and encoding 5 is unused.

Structure
REQ-035 Shared package ikaz_pkg holds the state enum/encodings (3-bit) and the default timing constants.
REQ-036 Sub-module ikaz_tick_gen (parameter TICK_DIV, ports clk, rst_n, tick) provides the ms tick; all other logic lives in ikaz_zil_kontrol.

Verification
Bench parameters for all scenarios: TICK_DIV=4, DEB_MS=3, SLOW 2/2, FAST 1/1, SLOW_CYC=2, FAST_CYC=3.
REQ-037 Motor=1, seatbelt=1 held -> DEB for 12 clk, then SLOW; zil toggles 8 clk on / 8 clk off twice; then FAST with 4 on / 4 off x3; then TIMEOUT with zil=0.
REQ-038 Seatbelt=1 for 8 clk then 0 -> FSM returns to IDLE from DEB, and zil never goes to 1.
REQ-039 kapi_ikaz=1 during the SLOW on-phase -> durum=3 on the next clk, and the fast pattern starts in its on-phase.
REQ-040 Motor drops to 0 in FAST -> IDLE and zil=0 one clk later; ikaz_aktif=0.
REQ-041 rst_n pulsed low mid-FAST -> zil=0 and durum=0 immediately; after release with request still held, 12 clk debounce is seen again.
REQ-042 With IKAZ_SUSTURMA_EN: mute pulse in SLOW -> durum=5, zil=0; then kapi_ikaz=1 -> durum=3 and beeping resumes.
